// File: rtl/control_pipe_regs_if.sv
// Decode-to-writeback control bus for control_pipe_regs.
// The master drives the ID-stage fields and the EX zero flag; the slave returns stage controls and hazard signals.
interface control_pipe_regs_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  i_id_reg_write;
  logic [1:0]            i_id_result_src;
  logic                  i_id_mem_write;
  logic [2:0]            i_id_alu_ctl;
  logic                  i_id_alu_src;
  logic                  i_id_branch;
  logic                  i_id_jump;
  logic                  i_id_jalr;
  logic [REG_ADDR_W-1:0] i_id_rs1;
  logic [REG_ADDR_W-1:0] i_id_rs2;
  logic [REG_ADDR_W-1:0] i_id_rd;
  logic                  i_ex_zero;

  logic [2:0]            o_ex_alu_ctl;
  logic                  o_ex_alu_src;
  logic [1:0]            o_ex_pc_src;
  logic                  o_mem_mem_write;
  logic                  o_mem_reg_write;
  logic [REG_ADDR_W-1:0] o_mem_rd;
  logic                  o_wb_reg_write;
  logic [1:0]            o_wb_result_src;
  logic [REG_ADDR_W-1:0] o_wb_rd;
  logic                  o_flush;
  logic                  o_stall;

  modport master (
    output i_id_reg_write, i_id_result_src, i_id_mem_write, i_id_alu_ctl,
           i_id_alu_src, i_id_branch, i_id_jump, i_id_jalr,
           i_id_rs1, i_id_rs2, i_id_rd, i_ex_zero,
    input  o_ex_alu_ctl, o_ex_alu_src, o_ex_pc_src, o_mem_mem_write,
           o_mem_reg_write, o_mem_rd, o_wb_reg_write, o_wb_result_src,
           o_wb_rd, o_flush, o_stall
  );

  modport slave (
    input  i_id_reg_write, i_id_result_src, i_id_mem_write, i_id_alu_ctl,
           i_id_alu_src, i_id_branch, i_id_jump, i_id_jalr,
           i_id_rs1, i_id_rs2, i_id_rd, i_ex_zero,
    output o_ex_alu_ctl, o_ex_alu_src, o_ex_pc_src, o_mem_mem_write,
           o_mem_reg_write, o_mem_rd, o_wb_reg_write, o_wb_result_src,
           o_wb_rd, o_flush, o_stall
  );
endinterface

// File: rtl/control_pipe_regs.sv
// ID/EX, EX/MEM, MEM/WB control registers with EX-stage redirect and load-use stall generation.
// Latency 1/2/3 edges to EX/MEM/WB; MEM/WB never stall. Load-use stall enabled by `define CTL_PIPE_LOAD_STALL_EN.
module control_pipe_regs #(
  parameter int REG_ADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  control_pipe_regs_if.slave bus
);

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [2:0]            alu_ctl;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctl_t;

  ex_ctl_t  r_ex;
  mem_ctl_t r_mem;
  wb_ctl_t  r_wb;

  ex_ctl_t    w_id;
  logic [1:0] w_pc_src;
  logic       w_flush;
  logic       w_load_use;
  logic       w_stall;
  logic       w_ex_bubble;

  always_comb begin
    w_id            = '0;
    w_id.reg_write  = bus.i_id_reg_write;
    w_id.result_src = bus.i_id_result_src;
    w_id.mem_write  = bus.i_id_mem_write;
    w_id.alu_ctl    = bus.i_id_alu_ctl;
    w_id.alu_src    = bus.i_id_alu_src;
    w_id.branch     = bus.i_id_branch;
    w_id.jump       = bus.i_id_jump;
    w_id.jalr       = bus.i_id_jalr;
    w_id.rd         = bus.i_id_rd;
  end

  // jalr outranks jal/branch so a malformed word with both bits still picks the register target.
  always_comb begin
    w_pc_src = PC_SEQ;
    if (r_ex.jalr) begin
      w_pc_src = PC_JALR;
    end else if (r_ex.jump || (r_ex.branch && bus.i_ex_zero)) begin
      w_pc_src = PC_TGT;
    end
  end

  assign w_flush = (w_pc_src != PC_SEQ);

`ifdef CTL_PIPE_LOAD_STALL_EN
  assign w_load_use = r_ex.reg_write
                   && (r_ex.result_src == RES_MEM)
                   && (r_ex.rd != '0)
                   && ((r_ex.rd == bus.i_id_rs1) || (r_ex.rd == bus.i_id_rs2));
`else
  assign w_load_use = 1'b0;
`endif

  // A redirect already squashes the ID instruction, so holding it would be wrong.
  assign w_stall     = w_load_use && !w_flush;
  assign w_ex_bubble = w_flush || w_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex <= '0;
    end else if (w_ex_bubble) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_id;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem <= '0;
    end else begin
      r_mem.reg_write  <= r_ex.reg_write;
      r_mem.result_src <= r_ex.result_src;
      r_mem.mem_write  <= r_ex.mem_write;
      r_mem.rd         <= r_ex.rd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb <= '0;
    end else begin
      r_wb.reg_write  <= r_mem.reg_write;
      r_wb.result_src <= r_mem.result_src;
      r_wb.rd         <= r_mem.rd;
    end
  end

  assign bus.o_ex_alu_ctl    = r_ex.alu_ctl;
  assign bus.o_ex_alu_src    = r_ex.alu_src;
  assign bus.o_ex_pc_src     = w_pc_src;
  assign bus.o_mem_mem_write = r_mem.mem_write;
  assign bus.o_mem_reg_write = r_mem.reg_write;
  assign bus.o_mem_rd        = r_mem.rd;
  assign bus.o_wb_reg_write  = r_wb.reg_write;
  assign bus.o_wb_result_src = r_wb.result_src;
  assign bus.o_wb_rd         = r_wb.rd;
  assign bus.o_flush         = w_flush;
  assign bus.o_stall         = w_stall;

endmodule

// File: tb/tb_control_pipe_regs.sv
// Bench for control_pipe_regs: directed hazard/redirect cases plus random traffic against an instruction-level pipeline model.
module tb_control_pipe_regs;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_pipe_regs_if #(.REG_ADDR_W(W)) bus ();
  control_pipe_regs #(.REG_ADDR_W(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit [2:0] alu;
    bit       asrc;
    bit       br;
    bit       j;
    bit       jr;
    bit [W-1:0] rd;
  } ins_t;

  ins_t m_ex, m_mem, m_wb, bub, cur;
  bit [W-1:0] cur_rs1, cur_rs2;
  bit cur_zero;
  int checks = 0;
  int errors = 0;

`ifdef CTL_PIPE_LOAD_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  function automatic ins_t mk(bit rw, bit [1:0] rs, bit mw, bit [2:0] alu, bit asrc,
                              bit br, bit j, bit jr, bit [W-1:0] rd);
    ins_t x;
    x.rw = rw; x.rs = rs; x.mw = mw; x.alu = alu; x.asrc = asrc;
    x.br = br; x.j = j; x.jr = jr; x.rd = rd;
    return x;
  endfunction

  function automatic bit [1:0] exp_pc();
    if (m_ex.jr) return 2'd2;
    if (m_ex.j || (m_ex.br && cur_zero)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit exp_stall();
    bit load;
    load = m_ex.rw && (m_ex.rs == 2'd1) && (m_ex.rd != 0)
        && ((m_ex.rd == cur_rs1) || (m_ex.rd == cur_rs2));
    return STALL_ON && load && (exp_pc() == 2'd0);
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ex_alu_ctl", 8'(bus.o_ex_alu_ctl), 8'(m_ex.alu));
    chk("ex_alu_src", 8'(bus.o_ex_alu_src), 8'(m_ex.asrc));
    chk("ex_pc_src", 8'(bus.o_ex_pc_src), 8'(exp_pc()));
    chk("flush", 8'(bus.o_flush), 8'(exp_pc() != 2'd0));
    chk("stall", 8'(bus.o_stall), 8'(exp_stall()));
    chk("mem_mem_write", 8'(bus.o_mem_mem_write), 8'(m_mem.mw));
    chk("mem_reg_write", 8'(bus.o_mem_reg_write), 8'(m_mem.rw));
    chk("mem_rd", 8'(bus.o_mem_rd), 8'(m_mem.rd));
    chk("wb_reg_write", 8'(bus.o_wb_reg_write), 8'(m_wb.rw));
    chk("wb_result_src", 8'(bus.o_wb_result_src), 8'(m_wb.rs));
    chk("wb_rd", 8'(bus.o_wb_rd), 8'(m_wb.rd));
  endtask

  task automatic drive(ins_t x, bit [W-1:0] rs1, bit [W-1:0] rs2, bit zero);
    cur = x; cur_rs1 = rs1; cur_rs2 = rs2; cur_zero = zero;
    bus.i_id_reg_write  = x.rw;
    bus.i_id_result_src = x.rs;
    bus.i_id_mem_write  = x.mw;
    bus.i_id_alu_ctl    = x.alu;
    bus.i_id_alu_src    = x.asrc;
    bus.i_id_branch     = x.br;
    bus.i_id_jump       = x.j;
    bus.i_id_jalr       = x.jr;
    bus.i_id_rd         = x.rd;
    bus.i_id_rs1        = rs1;
    bus.i_id_rs2        = rs2;
    bus.i_ex_zero       = zero;
    #1;
    check_all();
  endtask

  task automatic tick();
    bit squash;
    squash = (exp_pc() != 2'd0) || exp_stall();
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = squash ? bub : cur;
    #1;
  endtask

  task automatic reset_zero_checks();
    chk("rst_ex_alu_ctl", 8'(bus.o_ex_alu_ctl), 8'd0);
    chk("rst_pc_src", 8'(bus.o_ex_pc_src), 8'd0);
    chk("rst_flush", 8'(bus.o_flush), 8'd0);
    chk("rst_stall", 8'(bus.o_stall), 8'd0);
    chk("rst_mem_reg_write", 8'(bus.o_mem_reg_write), 8'd0);
    chk("rst_wb_reg_write", 8'(bus.o_wb_reg_write), 8'd0);
    chk("rst_wb_rd", 8'(bus.o_wb_rd), 8'd0);
  endtask

  ins_t nop, sub7, beq, add9, jalr1, lw3, lw0, add, ldjr, rnd;

  initial begin
    bub   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop   = bub;
    sub7  = mk(1, 2'b00, 0, 3'b001, 0, 0, 0, 0, 5'd7);
    beq   = mk(0, 2'b00, 0, 3'b001, 0, 1, 0, 0, 5'd0);
    add9  = mk(1, 2'b00, 0, 3'b010, 1, 0, 0, 0, 5'd9);
    jalr1 = mk(1, 2'b10, 0, 3'b000, 1, 0, 0, 1, 5'd1);
    lw3   = mk(1, 2'b01, 0, 3'b000, 1, 0, 0, 0, 5'd3);
    lw0   = mk(1, 2'b01, 0, 3'b000, 1, 0, 0, 0, 5'd0);
    add   = mk(1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 5'd8);
    ldjr  = mk(1, 2'b01, 0, 3'b000, 1, 0, 0, 1, 5'd4);
    m_ex = bub; m_mem = bub; m_wb = bub;

    rst = 1'b1;
    drive(nop, 0, 0, 0);
    #10 rst = 1'b0;
    reset_zero_checks();

    // R-type sub through all three banks
    drive(sub7, 1, 2, 0); tick();
    drive(nop, 0, 0, 0); chk("sub_ex_alu", 8'(bus.o_ex_alu_ctl), 8'd1); tick();
    drive(nop, 0, 0, 0); chk("sub_mem_rd", 8'(bus.o_mem_rd), 8'd7); tick();
    drive(nop, 0, 0, 0); chk("sub_wb_rd", 8'(bus.o_wb_rd), 8'd7);
    chk("sub_wb_src", 8'(bus.o_wb_result_src), 8'd0); tick();

    // beq not taken, then taken
    drive(beq, 1, 2, 0); tick();
    drive(add9, 1, 2, 0); chk("beq_nt_pc", 8'(bus.o_ex_pc_src), 8'd0);
    chk("beq_nt_flush", 8'(bus.o_flush), 8'd0); tick();
    drive(beq, 1, 2, 0); chk("beq_nt_ex_alu", 8'(bus.o_ex_alu_ctl), 8'd2); tick();
    drive(add9, 1, 2, 1); chk("beq_t_pc", 8'(bus.o_ex_pc_src), 8'd1);
    chk("beq_t_flush", 8'(bus.o_flush), 8'd1); tick();
    drive(nop, 0, 0, 0); chk("beq_t_bubble_alu", 8'(bus.o_ex_alu_ctl), 8'd0);
    chk("beq_t_bubble_src", 8'(bus.o_ex_alu_src), 8'd0); tick();

    // jalr rd=1
    drive(jalr1, 5, 0, 0); tick();
    drive(add9, 1, 2, 0); chk("jalr_pc", 8'(bus.o_ex_pc_src), 8'd2);
    chk("jalr_flush", 8'(bus.o_flush), 8'd1); tick();
    drive(nop, 0, 0, 0); tick();
    drive(nop, 0, 0, 0); chk("jalr_wb_src", 8'(bus.o_wb_result_src), 8'd2);
    chk("jalr_wb_rd", 8'(bus.o_wb_rd), 8'd1); tick();

    // load-use, then rd=0 load
    drive(lw3, 2, 0, 0); tick();
    drive(add, 3, 0, 0); chk("lu_stall", 8'(bus.o_stall), 8'(STALL_ON)); tick();
    drive(add, 3, 0, 0); chk("lu_stall_once", 8'(bus.o_stall), 8'd0); tick();
    drive(lw0, 2, 0, 0); tick();
    drive(add, 0, 0, 0); chk("lu_rd0_stall", 8'(bus.o_stall), 8'd0); tick();

    // load matching rs2 with jalr in EX: flush wins
    drive(ldjr, 1, 1, 0); tick();
    drive(add, 1, 4, 0); chk("pri_flush", 8'(bus.o_flush), 8'd1);
    chk("pri_stall", 8'(bus.o_stall), 8'd0); tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = mk($urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom_range(0, 1),
               3'($urandom), $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               W'($urandom_range(0, 7)));
      drive(rnd, W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), $urandom_range(0, 1));
      tick();
    end

    // mid-stream reset, then add x5 reaches WB three edges later
    drive(sub7, 0, 0, 0); tick();
    drive(lw3, 0, 0, 0); tick();
    #1 rst = 1'b1;
    #1;
    reset_zero_checks();
    m_ex = bub; m_mem = bub; m_wb = bub;
    rst = 1'b0;
    drive(mk(1, 2'b00, 0, 3'b000, 0, 0, 0, 0, 5'd5), 1, 2, 0); tick();
    drive(nop, 0, 0, 0); tick();
    drive(nop, 0, 0, 0); tick();
    drive(nop, 0, 0, 0);
    chk("post_rst_wb_rw", 8'(bus.o_wb_reg_write), 8'd1);
    chk("post_rst_wb_rd", 8'(bus.o_wb_rd), 8'd5);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_pipe_regs.md
# control_pipe_regs

Carries the decoded control word from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers. It sits downstream of `Control_Path` and consumes its decode outputs. It resolves branches and jumps in EX using the ALU zero flag. It also generates the flush and load-use stall that the IF/ID stage and PC logic consume.

## Interface
- REG_ADDR_W, default 5: register-index width.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  reset, asynchronous and active-high.
- i_id_reg_write  in  1  decoded write-back enable.
- i_id_result_src  in  2  00 ALU, 01 memory, 10 PC+4.
- i_id_mem_write  in  1  store enable.
- i_id_alu_ctl  in  3  ALU operation.
- i_id_alu_src  in  1  1 selects the immediate.
- i_id_branch  in  1  beq.
- i_id_jump  in  1  jal.
- i_id_jalr  in  1  jalr.
- i_id_rs1, i_id_rs2, i_id_rd  in  REG_ADDR_W each  register indices.
- i_ex_zero  in  1  ALU zero flag of the instruction currently in EX.
- o_ex_alu_ctl  out  3  EX-stage ALU operation.
- o_ex_alu_src  out  1  EX-stage immediate select.
- o_ex_pc_src  out  2  00 PC+4, 01 branch/jal target, 10 jalr target.
- o_mem_mem_write  out  1  MEM-stage store enable.
- o_mem_reg_write  out  1  MEM-stage write-back enable (forwarding).
- o_mem_rd  out  REG_ADDR_W  MEM-stage destination (forwarding).
- o_wb_reg_write  out  1  WB-stage register-file write enable.
- o_wb_result_src  out  2  WB-stage result select.
- o_wb_rd  out  REG_ADDR_W  WB-stage destination.
- o_flush  out  1  redirect taken; IF/ID must discard its instruction.
- o_stall  out  1  load-use hazard; PC and IF/ID must hold.

## Operation
- Three register banks, named by the stage they drive: EX (ID/EX), MEM (EX/MEM), WB (MEM/WB).
- EX captures all i_id_* fields. MEM takes reg_write, result_src, mem_write and rd from EX. WB takes the same fields from MEM.
- Bubble: every control bit is 0, result_src is 00, and rd is 0. A bubble has no architectural effect.
- Redirect, combinational from the EX bank:
  - o_ex_pc_src = 10 if jalr.
  - else 01 if jump, or if branch and i_ex_zero.
  - else 00.
- o_flush = (o_ex_pc_src != 00).
- On o_flush, the EX bank loads a bubble at the next edge. This squashes the wrong-path instruction in ID.
- The redirecting instruction itself still advances to MEM. jal/jalr therefore write PC+4.
- Load-use hazard: the EX bank holds a load (reg_write=1, result_src=01, rd≠0) and rd equals i_id_rs1 or i_id_rs2.
  - o_stall is asserted.
  - The EX bank loads a bubble; MEM and WB advance normally.
- Flush has priority. When o_flush and the load-use condition coincide, o_stall is forced to 0.
- rd = 0 never triggers a stall.
- MEM and WB always advance; there is no back-pressure from memory.

## Timing
- Asynchronous reset clears every bank to a bubble immediately. After reset:
  - all outputs are 0, o_ex_pc_src = 00, o_flush = 0, o_stall = 0.
- Reset asserted mid-operation discards all in-flight instructions. The first edge after deassertion samples ID normally.
- Latency from ID presentation: EX outputs 1 edge, MEM outputs 2 edges, WB outputs 3 edges.
- o_ex_pc_src, o_flush and o_stall are combinational within the cycle. There is no registered delay.
- A taken redirect costs exactly 1 squashed instruction. A load-use hazard costs exactly 1 bubble, with o_stall high for one cycle.
- A stall followed by a taken branch in the cycle after still flushes correctly, because flush is evaluated on the new EX contents.

## Configuration
- CTL_PIPE_LOAD_STALL_EN
  - Defined: load-use detection and o_stall are active as described above.
  - Undefined: o_stall is tied to 0 and no stall bubbles are inserted. The software toolchain guarantees load-use spacing.

## Test plan
- Reset: assert i_rst mid-stream -> all outputs 0 at once; add x5 presented after release -> o_wb_reg_write=1, o_wb_rd=5 three edges later.
- R-type sub (alu_ctl 001, reg_write 1, rd 7) -> o_ex_alu_ctl=001 at edge 1; o_mem_rd=7 at edge 2; o_wb_rd=7, o_wb_result_src=00 at edge 3.
- beq with i_ex_zero=0 -> o_ex_pc_src=00, o_flush=0. Repeat with i_ex_zero=1 -> o_ex_pc_src=01, o_flush=1; next EX bank is a bubble.
- jalr rd=1 -> o_ex_pc_src=10, o_flush=1; o_wb_result_src=10 and o_wb_rd=1 two edges later.
- lw x3, followed by add with rs1=3 -> o_stall=1 for one cycle with macro defined, 0 without. Same sequence with rd=0 -> o_stall=0.
- Load in EX matching ID rs2 while a jalr is also in EX -> o_flush=1, o_stall=0.
